// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: request, write-port and forward signals of the register file write arbiter
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              forward_valid;
    logic [ADDR_W-1:0] forward_addr;
    logic [DATA_W-1:0] forward_data;
    logic [2:0]        starve_cnt;

    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready, write_addr, write_data,
               forward_valid, forward_addr, forward_data, starve_cnt
    );

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready, write_addr, write_data,
               forward_valid, forward_addr, forward_data, starve_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between ALU and load-return results
module regfile_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int MAX_STARVE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);
    localparam logic [2:0] MAX_Q = 3'(MAX_STARVE);

    logic              alu_nz, mem_nz, alu_win, mem_win, fwd_v;
    logic [ADDR_W-1:0] fwd_a, write_addr_q, write_addr_d;
    logic [DATA_W-1:0] fwd_w, write_data_q, write_data_d;
    logic [2:0]        starve_q, starve_d;

    // Grant one nonzero-destination request; same-address pairs always go to the older load
    always_comb begin
        alu_nz       = bus.alu_valid && (bus.alu_addr != '0);
        mem_nz       = bus.mem_valid && (bus.mem_addr != '0);
        alu_win      = alu_nz && (!mem_nz || (starve_q == MAX_Q && bus.alu_addr != bus.mem_addr));
        mem_win      = mem_nz && !alu_win;
        fwd_v        = alu_win || mem_win;
        fwd_a        = alu_win ? bus.alu_addr : mem_win ? bus.mem_addr : '0;
        fwd_w        = alu_win ? bus.alu_data : mem_win ? bus.mem_data : '0;
        starve_d     = (!bus.alu_valid || bus.alu_addr == '0 || alu_win) ? 3'd0 :
                       (starve_q == MAX_Q) ? MAX_Q : starve_q + 3'd1;
        write_addr_d = fwd_v ? fwd_a : '0;
        write_data_d = fwd_v ? fwd_w : write_data_q;
    end

    assign bus.alu_ready     = bus.alu_valid && (bus.alu_addr == '0 || alu_win);
    assign bus.mem_ready     = bus.mem_valid && (bus.mem_addr == '0 || mem_win);
    assign bus.forward_valid = fwd_v;
    assign bus.forward_addr  = fwd_a;
    assign bus.forward_data  = fwd_w;
    assign bus.write_addr    = write_addr_q;
    assign bus.write_data    = write_data_q;
    assign bus.starve_cnt    = starve_q;

    // Register the granted write and the ALU starvation count
    always_ff @(posedge clk) begin
        if (rst) begin
            write_addr_q <= '0;
            write_data_q <= '0;
            starve_q     <= '0;
        end else begin
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            starve_q     <= starve_d;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of grant, forwarding, starvation and ordering
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(4), .MAX_STARVE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [3:0] ma, input logic [31:0] md);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("rst_waddr", 32'(bus.write_addr), 0);
        chk("rst_wdata", bus.write_data, 0);
        chk("rst_starve", 32'(bus.starve_cnt), 0);
        chk("rst_aready", 32'(bus.alu_ready), 0);
        chk("rst_mready", 32'(bus.mem_ready), 0);
        chk("rst_fvalid", 32'(bus.forward_valid), 0);
        rst = 1'b0;
        step();

        drive(1, 3, 32'h11, 0, 0, 0);
        #1;
        chk("solo_aready", 32'(bus.alu_ready), 1);
        chk("solo_fvalid", 32'(bus.forward_valid), 1);
        chk("solo_faddr", 32'(bus.forward_addr), 3);
        chk("solo_fdata", bus.forward_data, 32'h11);
        chk("solo_waddr_pre", 32'(bus.write_addr), 0);
        step();
        chk("solo_waddr", 32'(bus.write_addr), 3);
        chk("solo_wdata", bus.write_data, 32'h11);
        drive(0, 0, 0, 0, 0, 0);

        drive(1, 2, 32'hAA, 1, 5, 32'h55);
        #1;
        chk("cont_mready", 32'(bus.mem_ready), 1);
        chk("cont_aready", 32'(bus.alu_ready), 0);
        chk("cont_faddr", 32'(bus.forward_addr), 5);
        step();
        chk("cont_waddr", 32'(bus.write_addr), 5);
        chk("cont_wdata", bus.write_data, 32'h55);
        chk("cont_starve", 32'(bus.starve_cnt), 1);
        drive(1, 2, 32'hAA, 0, 0, 0);
        #1;
        chk("cont_aready2", 32'(bus.alu_ready), 1);
        step();
        chk("cont_waddr2", 32'(bus.write_addr), 2);
        chk("cont_starve2", 32'(bus.starve_cnt), 0);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("idle_fvalid", 32'(bus.forward_valid), 0);
        chk("idle_faddr", 32'(bus.forward_addr), 0);
        chk("idle_fdata", bus.forward_data, 0);
        step();
        chk("idle_waddr", 32'(bus.write_addr), 0);
        chk("idle_wdata_hold", bus.write_data, 32'hAA);

        for (int i = 0; i < 4; i++) begin
            drive(1, 2, 32'hA2, 1, 5, 32'h50 + 32'(i));
            #1;
            chk("stv_starve", 32'(bus.starve_cnt), 32'(i));
            chk("stv_aready", 32'(bus.alu_ready), 0);
            chk("stv_mready", 32'(bus.mem_ready), 1);
            step();
            chk("stv_wdata", bus.write_data, 32'h50 + 32'(i));
        end
        drive(1, 2, 32'hA2, 1, 5, 32'h54);
        #1;
        chk("stv_starve_max", 32'(bus.starve_cnt), 4);
        chk("stv_aready_ovr", 32'(bus.alu_ready), 1);
        chk("stv_mready_ovr", 32'(bus.mem_ready), 0);
        chk("stv_faddr_ovr", 32'(bus.forward_addr), 2);
        step();
        chk("stv_waddr_ovr", 32'(bus.write_addr), 2);
        chk("stv_wdata_ovr", bus.write_data, 32'hA2);
        chk("stv_starve_clr", 32'(bus.starve_cnt), 0);
        drive(0, 0, 0, 1, 5, 32'h54);
        #1;
        chk("stv_mready_late", 32'(bus.mem_ready), 1);
        step();
        chk("stv_wdata_late", bus.write_data, 32'h54);
        drive(0, 0, 0, 0, 0, 0);
        step();

        for (int i = 0; i < 5; i++) begin
            drive(1, 7, 32'h77, 1, 7, 32'h70 + 32'(i));
            #1;
            chk("same_starve", 32'(bus.starve_cnt), (i < 4) ? 32'(i) : 4);
            chk("same_mready", 32'(bus.mem_ready), 1);
            chk("same_aready", 32'(bus.alu_ready), 0);
            step();
            chk("same_waddr", 32'(bus.write_addr), 7);
            chk("same_wdata", bus.write_data, 32'h70 + 32'(i));
        end
        chk("same_starve_sat", 32'(bus.starve_cnt), 4);
        drive(1, 7, 32'h77, 0, 0, 0);
        #1;
        chk("same_aready_last", 32'(bus.alu_ready), 1);
        step();
        chk("same_waddr_last", 32'(bus.write_addr), 7);
        chk("same_wdata_last", bus.write_data, 32'h77);
        chk("same_starve_clr", 32'(bus.starve_cnt), 0);

        drive(1, 0, 32'h99, 1, 4, 32'h44);
        #1;
        chk("disc_aready", 32'(bus.alu_ready), 1);
        chk("disc_mready", 32'(bus.mem_ready), 1);
        chk("disc_faddr", 32'(bus.forward_addr), 4);
        chk("disc_fdata", bus.forward_data, 32'h44);
        step();
        chk("disc_waddr", 32'(bus.write_addr), 4);
        chk("disc_wdata", bus.write_data, 32'h44);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("disc_waddr_once", 32'(bus.write_addr), 0);

        drive(1, 0, 32'h98, 0, 0, 0);
        #1;
        chk("disc_solo_aready", 32'(bus.alu_ready), 1);
        chk("disc_solo_fvalid", 32'(bus.forward_valid), 0);
        step();
        chk("disc_solo_waddr", 32'(bus.write_addr), 0);

        for (int i = 0; i < 2; i++) begin
            drive(1, 2, 32'hB2, 1, 5, 32'h60 + 32'(i));
            step();
        end
        chk("rstc_starve_pre", 32'(bus.starve_cnt), 2);
        rst = 1'b1;
        drive(1, 2, 32'hB2, 1, 5, 32'h62);
        step();
        chk("rstc_starve", 32'(bus.starve_cnt), 0);
        chk("rstc_waddr", 32'(bus.write_addr), 0);
        rst = 1'b0;
        #1;
        chk("rstc_mready", 32'(bus.mem_ready), 1);
        step();
        chk("rstc_starve_re", 32'(bus.starve_cnt), 1);
        chk("rstc_waddr_re", 32'(bus.write_addr), 5);
        drive(0, 0, 0, 0, 0, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
